// File: rtl/ms_riscv32_mp_pkg.sv
// Shared AHB-Lite constants and types for the ms_riscv32_mp core.
// Bus encodings, transfer owner enum and address-phase bundle.
package ms_riscv32_mp_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
  } ahb_aph_t;

endpackage

// File: rtl/ms_riscv32_mp_arb_size_dec.sv
// Byte-enable mask to AHB hsize decode for the data port.
// Unlisted masks fall back to a full word.
module ms_riscv32_mp_arb_size_dec
  import ms_riscv32_mp_pkg::*;
(
  input  logic [3:0] mask,
  output logic [2:0] hsize
);

  // Map the load/store byte enables onto a transfer size
  always_comb begin
    hsize = HSIZE_WORD;
    unique case (mask)
      4'b0011, 4'b1100:
        hsize = HSIZE_HALF;
      4'b0001, 4'b0010, 4'b0100, 4'b1000:
        hsize = HSIZE_BYTE;
      default:
        hsize = HSIZE_WORD;
    endcase
  end

endmodule

// File: rtl/ms_riscv32_mp_ahb_arbiter.sv
// Fetch / load-store arbiter onto one AHB-Lite master port.
// Optional fetch starvation guard: MS_RISCV32_MP_ARB_STARVE_EN.
module ms_riscv32_mp_ahb_arbiter
  import ms_riscv32_mp_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        if_req_in,
  input  logic [31:0] if_addr_in,
  output logic        if_gnt_out,
  output logic        if_rvalid_out,
  output logic        if_err_out,
  output logic [31:0] if_rdata_out,
  input  logic        dm_req_in,
  input  logic        dm_we_in,
  input  logic [31:0] dm_addr_in,
  input  logic [31:0] dm_wdata_in,
  input  logic [3:0]  dm_mask_in,
  output logic        dm_gnt_out,
  output logic        dm_rvalid_out,
  output logic        dm_err_out,
  output logic [31:0] dm_rdata_out,
  output logic [31:0] haddr_out,
  output logic [1:0]  htrans_out,
  output logic        hwrite_out,
  output logic [2:0]  hsize_out,
  output logic [31:0] hwdata_out,
  input  logic [31:0] hrdata_in,
  input  logic        hready_in,
  input  logic        hresp_in
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be 1..15");
  end

  owner_e      owner_q;
  logic        err_q;
  logic [31:0] hwdata_q;
  logic [2:0]  dm_size;
  logic        open;
  logic        pick_if;
  logic        pick_dm;
  logic        done;
  ahb_aph_t    aph;

  ms_riscv32_mp_arb_size_dec u_size_dec (
    .mask  (dm_mask_in),
    .hsize (dm_size)
  );

`ifdef MS_RISCV32_MP_ARB_STARVE_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_q;

  // Fetch overrides data once the data port has had its run
  always_comb begin
    pick_if = if_req_in && (starve_q >= LIMIT || !dm_req_in);
    pick_dm = dm_req_in && !pick_if;
  end

  // Count data grants that pass over a waiting fetch
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      starve_q <= 4'd0;
    end else if (if_gnt_out || !if_req_in) begin
      starve_q <= 4'd0;
    end else if (dm_gnt_out && starve_q != 4'hf) begin
      starve_q <= starve_q + 4'd1;
    end
  end
`else
  // Data port has fixed absolute priority
  always_comb begin
    pick_dm = dm_req_in;
    pick_if = if_req_in && !dm_req_in;
  end
`endif

  // Address phase: grant only on a free bus with no pending error
  always_comb begin
    open       = ms_riscv32_mp_rst_in && hready_in && !err_q;
    if_gnt_out = open && pick_if;
    dm_gnt_out = open && pick_dm;
    aph        = '0;
    unique case (1'b1)
      dm_gnt_out: aph = '{addr: dm_addr_in, write: dm_we_in, size: dm_size};
      if_gnt_out: aph = '{addr: if_addr_in, write: 1'b0, size: HSIZE_WORD};
      default:    aph = '0;
    endcase
    htrans_out = (if_gnt_out || dm_gnt_out) ? HTRANS_NONSEQ : HTRANS_IDLE;
    haddr_out  = aph.addr;
    hwrite_out = aph.write;
    hsize_out  = aph.size;
    hwdata_out = hwdata_q;
  end

  // Data phase: route completion back to the owner only
  always_comb begin
    done          = (owner_q != OWN_NONE) && hready_in;
    if_rvalid_out = done && (owner_q == OWN_IF);
    dm_rvalid_out = done && (owner_q == OWN_DM);
    if_err_out    = if_rvalid_out && (hresp_in || err_q);
    dm_err_out    = dm_rvalid_out && (hresp_in || err_q);
    if_rdata_out  = (if_rvalid_out && !err_q) ? hrdata_in : 32'h0;
    dm_rdata_out  = (dm_rvalid_out && !err_q) ? hrdata_in : 32'h0;
  end

  // Track owner, error first cycle and write data
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      owner_q  <= OWN_NONE;
      err_q    <= 1'b0;
      hwdata_q <= 32'h0;
    end else begin
      if (if_gnt_out) begin
        owner_q <= OWN_IF;
      end else if (dm_gnt_out) begin
        owner_q <= OWN_DM;
      end else if (hready_in) begin
        owner_q <= OWN_NONE;
      end
      if (hready_in) begin
        err_q <= 1'b0;
      end else if (hresp_in && owner_q != OWN_NONE) begin
        err_q <= 1'b1;
      end
      if (dm_gnt_out && dm_we_in) begin
        hwdata_q <= dm_wdata_in;
      end
    end
  end

endmodule

// File: tb/tb_ms_riscv32_mp_ahb_arbiter.sv
// Scoreboard bench for the fetch / load-store AHB arbiter.
// Responses are queued at grant and checked on rvalid.
module tb_ms_riscv32_mp_ahb_arbiter;

  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] data;
    logic        err;
  } exp_t;

  localparam logic [1:0] SRC_IF = 2'b01;
  localparam logic [1:0] SRC_DM = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = 32'h0;
  logic [31:0] dm_wdata = 32'h0;
  logic [3:0]  dm_mask = 4'hf;
  logic        dm_gnt, dm_rvalid, dm_err;
  logic [31:0] dm_rdata;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hrdata = 32'h0;
  logic        hready = 1'b1;
  logic        hresp = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int n_push = 0;
  int n_pop = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ms_riscv32_mp_ahb_arbiter #(.STARVE_LIMIT(4)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst_n),
    .if_req_in     (if_req),
    .if_addr_in    (if_addr),
    .if_gnt_out    (if_gnt),
    .if_rvalid_out (if_rvalid),
    .if_err_out    (if_err),
    .if_rdata_out  (if_rdata),
    .dm_req_in     (dm_req),
    .dm_we_in      (dm_we),
    .dm_addr_in    (dm_addr),
    .dm_wdata_in   (dm_wdata),
    .dm_mask_in    (dm_mask),
    .dm_gnt_out    (dm_gnt),
    .dm_rvalid_out (dm_rvalid),
    .dm_err_out    (dm_err),
    .dm_rdata_out  (dm_rdata),
    .haddr_out     (haddr),
    .htrans_out    (htrans),
    .hwrite_out    (hwrite),
    .hsize_out     (hsize),
    .hwdata_out    (hwdata),
    .hrdata_in     (hrdata),
    .hready_in     (hready),
    .hresp_in      (hresp)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] src, input logic [31:0] d,
                      input logic e);
    sb.push_back('{src: src, data: d, err: e});
    n_push++;
  endtask

  // Scoreboard: every completion must match the oldest queued response
  always @(negedge clk) begin
    if (if_rvalid || dm_rvalid) begin
      exp_t e;
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_pop++;
        chk("rv_src", {30'h0, dm_rvalid, if_rvalid}, {30'h0, e.src});
        if (e.src == SRC_IF) begin
          chk("if_rdata", if_rdata, e.data);
          chk("if_err", {31'h0, if_err}, {31'h0, e.err});
          chk("dm_rdata_idle", dm_rdata, 32'h0);
        end else begin
          chk("dm_rdata", dm_rdata, e.data);
          chk("dm_err", {31'h0, dm_err}, {31'h0, e.err});
          chk("if_rdata_idle", if_rdata, 32'h0);
        end
      end
    end
  end

  logic [3:0] masks [8];
  logic [2:0] sizes [8];
  logic [1:0] w;

  initial begin
    masks = '{4'b1111, 4'b0011, 4'b1100, 4'b0001,
              4'b0010, 4'b0100, 4'b1000, 4'b0110};
    sizes = '{3'b010, 3'b001, 3'b001, 3'b000,
              3'b000, 3'b000, 3'b000, 3'b010};

    // reset state with live requests
    if_req  = 1'b1;
    if_addr = 32'h0000_0abc;
    dm_req  = 1'b1;
    dm_addr = 32'h0000_0def;
    @(negedge clk);
    chk("rst_if_gnt", {31'h0, if_gnt}, 32'd0);
    chk("rst_dm_gnt", {31'h0, dm_gnt}, 32'd0);
    chk("rst_htrans", {30'h0, htrans}, 32'd0);
    chk("rst_haddr", haddr, 32'h0);
    chk("rst_hsize", {29'h0, hsize}, 32'd0);
    chk("rst_hwdata", hwdata, 32'h0);
    chk("rst_rvalid", {30'h0, if_rvalid, dm_rvalid}, 32'd0);
    if_req = 1'b0;
    dm_req = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single fetch
    tick();
    if_req  = 1'b1;
    if_addr = 32'h0000_0100;
    @(negedge clk);
    chk("f_gnt", {31'h0, if_gnt}, 32'd1);
    chk("f_htrans", {30'h0, htrans}, 32'h2);
    chk("f_haddr", haddr, 32'h0000_0100);
    chk("f_hsize", {29'h0, hsize}, 32'h2);
    chk("f_hwrite", {31'h0, hwrite}, 32'd0);
    push(SRC_IF, 32'hdead_beef, 1'b0);
    tick();
    if_req = 1'b0;
    hrdata = 32'hdead_beef;
    @(negedge clk);
    chk("f_rvalid", {31'h0, if_rvalid}, 32'd1);
    tick();
    hrdata = 32'h0;

    // data write beats a fetch
    tick();
    if_req   = 1'b1;
    if_addr  = 32'h0000_0104;
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 32'h2000_0002;
    dm_mask  = 4'b1100;
    dm_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("w_dm_gnt", {31'h0, dm_gnt}, 32'd1);
    chk("w_if_gnt", {31'h0, if_gnt}, 32'd0);
    chk("w_hsize", {29'h0, hsize}, 32'h1);
    chk("w_hwrite", {31'h0, hwrite}, 32'd1);
    chk("w_haddr", haddr, 32'h2000_0002);
    push(SRC_DM, 32'h0, 1'b0);
    tick();
    dm_req = 1'b0;
    dm_we  = 1'b0;
    @(negedge clk);
    chk("w_hwdata", hwdata, 32'h1234_5678);
    chk("w_if_gnt2", {31'h0, if_gnt}, 32'd1);
    chk("w_haddr2", haddr, 32'h0000_0104);
    push(SRC_IF, 32'hcafe_0001, 1'b0);
    tick();
    if_req = 1'b0;
    hrdata = 32'hcafe_0001;
    @(negedge clk);
    chk("w_hwdata_hold", hwdata, 32'h1234_5678);
    tick();
    hrdata = 32'h0;

    // back-to-back loads across every mask
    for (int i = 0; i <= 8; i++) begin
      tick();
      hrdata = (i > 0) ? 32'ha5a5_0000 + 32'(i - 1) : 32'h0;
      if (i < 8) begin
        dm_req  = 1'b1;
        dm_mask = masks[i];
        dm_addr = 32'h0000_1000 + 32'(i * 4);
      end else begin
        dm_req  = 1'b0;
      end
      @(negedge clk);
      if (i < 8) begin
        chk("bb_gnt", {31'h0, dm_gnt}, 32'd1);
        chk("bb_hsize", {29'h0, hsize}, {29'h0, sizes[i]});
        push(SRC_DM, 32'ha5a5_0000 + 32'(i), 1'b0);
      end
    end
    tick();
    hrdata  = 32'h0;
    dm_mask = 4'hf;

    // contention: starvation guard or fixed priority
    for (int k = 0; k < 10; k++) begin
      tick();
      hrdata = (k > 0) ? 32'h5100_0000 + 32'(k - 1) : 32'h0;
      if_req = 1'b1;
      dm_req = 1'b1;
      @(negedge clk);
`ifdef MS_RISCV32_MP_ARB_STARVE_EN
      w = (k % 5 == 4) ? SRC_IF : SRC_DM;
`else
      w = SRC_DM;
`endif
      chk("st_gnt", {30'h0, dm_gnt, if_gnt}, {30'h0, w});
      push(w, 32'h5100_0000 + 32'(k), 1'b0);
    end
    tick();
    if_req = 1'b0;
    dm_req = 1'b0;
    hrdata = 32'h5100_0009;
    tick();
    hrdata = 32'h0;

    // two wait states on a load while fetch waits
    tick();
    dm_req  = 1'b1;
    dm_addr = 32'h0000_3000;
    @(negedge clk);
    chk("ws_gnt", {31'h0, dm_gnt}, 32'd1);
    push(SRC_DM, 32'h7777_0000, 1'b0);
    for (int j = 0; j < 2; j++) begin
      tick();
      dm_req = 1'b0;
      if_req = 1'b1;
      hready = 1'b0;
      @(negedge clk);
      chk("ws_nogrant", {30'h0, dm_gnt, if_gnt}, 32'd0);
      chk("ws_htrans", {30'h0, htrans}, 32'd0);
      chk("ws_norv", {31'h0, dm_rvalid}, 32'd0);
    end
    tick();
    hready = 1'b1;
    hrdata = 32'h7777_0000;
    @(negedge clk);
    chk("ws_rvalid", {31'h0, dm_rvalid}, 32'd1);
    chk("ws_if_gnt", {31'h0, if_gnt}, 32'd1);
    push(SRC_IF, 32'h8888_0000, 1'b0);
    tick();
    if_req = 1'b0;
    hrdata = 32'h8888_0000;
    tick();
    hrdata = 32'h0;

    // error response on a fetch
    tick();
    if_req  = 1'b1;
    if_addr = 32'h0000_0200;
    @(negedge clk);
    chk("er_gnt", {31'h0, if_gnt}, 32'd1);
    push(SRC_IF, 32'h0, 1'b1);
    tick();
    hready = 1'b0;
    hresp  = 1'b1;
    hrdata = 32'hffff_ffff;
    @(negedge clk);
    chk("er1_htrans", {30'h0, htrans}, 32'd0);
    chk("er1_gnt", {31'h0, if_gnt}, 32'd0);
    chk("er1_norv", {31'h0, if_rvalid}, 32'd0);
    tick();
    hready = 1'b1;
    @(negedge clk);
    chk("er2_rvalid", {31'h0, if_rvalid}, 32'd1);
    chk("er2_err", {31'h0, if_err}, 32'd1);
    chk("er2_rdata", if_rdata, 32'h0);
    chk("er2_htrans", {30'h0, htrans}, 32'd0);
    chk("er2_gnt", {31'h0, if_gnt}, 32'd0);
    tick();
    if_req = 1'b0;
    hresp  = 1'b0;
    hrdata = 32'h0;
    @(negedge clk);
    chk("er3_norv", {30'h0, if_rvalid, if_err}, 32'd0);

    // reset in the middle of a data phase
    tick();
    dm_req  = 1'b1;
    dm_addr = 32'h0000_0400;
    @(negedge clk);
    chk("rs_gnt", {31'h0, dm_gnt}, 32'd1);
    tick();
    dm_req = 1'b0;
    hready = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    chk("rs_htrans", {30'h0, htrans}, 32'd0);
    chk("rs_norv", {31'h0, dm_rvalid}, 32'd0);
    tick();
    rst_n  = 1'b1;
    hready = 1'b1;
    hrdata = 32'hbad0_bad0;
    @(negedge clk);
    chk("rs_norv2", {31'h0, dm_rvalid}, 32'd0);
    chk("rs_htrans2", {30'h0, htrans}, 32'd0);
    tick();
    if_req  = 1'b1;
    if_addr = 32'h0000_0500;
    @(negedge clk);
    chk("rs_first_gnt", {31'h0, if_gnt}, 32'd1);
    push(SRC_IF, 32'h0bad_f00d, 1'b0);
    tick();
    if_req = 1'b0;
    hrdata = 32'h0bad_f00d;
    tick();
    hrdata = 32'h0;
    tick();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("sb_count", 32'(n_pop), 32'(n_push));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ms_riscv32_mp_ahb_arbiter.md
# ms_riscv32_mp_ahb_arbiter

Two-requester arbiter that shares the core's single AHB-Lite master port between the instruction-fetch unit and the load/store unit. It sits between the pipeline's fetch/memory stages and the external bus. It issues pipelined NONSEQ single transfers, tracks which requester owns the outstanding data phase, and routes read data, completion and error back to that owner. Data accesses have priority; an optional starvation guard protects instruction fetch.

## Interface
- STARVE_LIMIT, 4: consecutive data-port grants allowed while a fetch is pending before fetch is forced through (1..15).
- ms_riscv32_mp_clk_in  in  1  core clock; all state on rising edge.
- ms_riscv32_mp_rst_in  in  1  asynchronous, active-low reset.
- if_req_in  in  1  fetch request; held until granted.
- if_addr_in  in  32  fetch word address, word-aligned.
- if_gnt_out  out  1  fetch address phase accepted this cycle.
- if_rvalid_out / if_err_out  out  1 / 1  fetch data phase complete / completed with ERROR.
- if_rdata_out  out  32  fetch read data, valid with if_rvalid_out.
- dm_req_in, dm_we_in  in  1, 1  data request; 1 = write.
- dm_addr_in  in  32  data byte address.
- dm_wdata_in  in  32  write data, sampled at grant.
- dm_mask_in  in  4  byte enables: 4'b1111, 4'b0011, 4'b1100, or one-hot.
- dm_gnt_out, dm_rvalid_out, dm_err_out  out  1 each  as fetch equivalents.
- dm_rdata_out  out  32  load data.
- haddr_out  out  32; htrans_out  out  2; hwrite_out  out  1; hsize_out  out  3; hwdata_out  out  32.
- hrdata_in  in  32; hready_in  in  1; hresp_in  in  1 (1 = ERROR).

## Operation
- Address phase (combinational): when hready_in=1 and a request is selected, htrans_out=NONSEQ (2'b10), haddr/hwrite/hsize driven from the winner, and the winner's gnt_out=1. Otherwise htrans_out=IDLE, all gnt_out=0.
- Selection: dm_req_in wins over if_req_in. Fetch always uses hwrite=0, hsize=WORD.
- hsize from dm_mask_in: 1111→3'b010, 0011/1100→3'b001, one-hot→3'b000. Any other mask is treated as 1111. haddr passes unmodified.
- Owner register {NONE, IF, DM} loads the winner on grant. It loads NONE when hready_in=1 and nothing is granted. hwdata_out is a register loaded with dm_wdata_in on a write grant, otherwise held.
- Data phase completes on the first cycle with owner≠NONE and hready_in=1. In that cycle the owner's rvalid_out=1 and rdata_out=hrdata_in. err_out=hresp_in.
- Error response: a cycle with hready_in=0 and hresp_in=1 forces htrans_out=IDLE and suppresses all grants, even if hready_in rises next cycle. In the following hready_in=1 cycle the owner gets rvalid=1, err=1, rdata=32'h0.
- Simultaneous completion and new grant are legal. Back-to-back transfers sustain one per cycle.
- Rdata outputs for the non-owner are 32'h0.

## Timing
- Grant to rvalid: 1 cycle minimum, plus 1 cycle per hready_in=0 wait state.
- At most one outstanding data phase.
- Reset (async assert) clears owner to NONE, starve counter to 0, hwdata_out to 0, and error flag to 0.
- While reset is asserted, all gnt/rvalid/err outputs are 0, htrans_out=IDLE, and haddr/hsize/hwrite are 0.
- Reset mid-transfer drops the outstanding response. No rvalid is issued after release.
- Release is synchronous-safe: the first grant can occur on the first clock edge after deassertion.

## Configuration
- MS_RISCV32_MP_ARB_STARVE_EN defined: a 4-bit counter increments on each dm grant while if_req_in=1. It clears on any if grant or when if_req_in=0. When the count reaches STARVE_LIMIT, fetch wins the next arbitration regardless of dm_req_in.
- Not defined: the counter is absent, and the data port has fixed absolute priority.

## Structure
- Shared package ms_riscv32_mp_pkg holds:
  - HTRANS_IDLE / HTRANS_NONSEQ constants,
  - HSIZE_BYTE / HALF / WORD constants,
  - the owner enum type.
- One sub-module, ms_riscv32_mp_arb_size_dec, performs the combinational mask→hsize decode.

## Test plan
- if_req only, addr 32'h0000_0100, hready=1, hrdata=32'hDEAD_BEEF: if_gnt in cycle 0, htrans=2'b10; if_rvalid with rdata DEAD_BEEF in cycle 1.
- if_req and dm_req together, dm write of 32'h1234_5678 to 32'h2000_0002 with mask 1100: dm granted first with hsize=001; hwdata=1234_5678 in cycle 1; if granted cycle 1.
- With STARVE_EN and STARVE_LIMIT=4, dm_req and if_req held continuously: grant pattern is 4×dm then 1×if, repeating. Without the macro, if is never granted.
- Two wait states (hready=0,0,1) on a dm load: no grants during the waits; dm_rvalid in the 3rd cycle after grant.
- ERROR response on a fetch (hready=0 with hresp=1, then hready=1 with hresp=1): htrans IDLE in the first cycle; if_err=1, if_rvalid=1, rdata=0 in the second cycle.
- Reset asserted the cycle after a dm grant: no dm_rvalid after release, htrans IDLE, owner NONE.
